// File: rtl/hpi_bus_master_if.sv
// Avalon-side request signals and HPI pad signals of the HPI bus master.
// The master modport is the controller's view; slave is the peer/environment view.
interface hpi_bus_master_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        waitrequest;
  logic [1:0]  otg_addr;
  logic [15:0] otg_data_out;
  logic        otg_data_oe;
  logic [15:0] otg_data_in;
  logic        otg_cs_n;
  logic        otg_rd_n;
  logic        otg_wr_n;
  logic        otg_rst_n;

  modport master (
    input  address, read, write, writedata, otg_data_in,
    output readdata, waitrequest, otg_addr, otg_data_out, otg_data_oe,
    output otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n
  );

  modport slave (
    output address, read, write, writedata, otg_data_in,
    input  readdata, waitrequest, otg_addr, otg_data_out, otg_data_oe,
    input  otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n
  );
endinterface

// File: rtl/hpi_bus_master.sv
// Avalon-to-HPI bridge: sequences cs_n/rd_n/wr_n with programmable setup, strobe,
// hold and recovery times, plus a local CTRL register driving the chip reset.
module hpi_bus_master #(
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned STROBE_CYC   = 6,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned RECOVERY_CYC = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  hpi_bus_master_if.master  bus
);

  // Counter load value: phase lasts (load + 1) cycles; 0 behaves as 1.
  function automatic logic [3:0] load_val(input int unsigned n);
    if (n == 0)      return 4'd0;
    else if (n > 15) return 4'd14;
    else             return 4'(n - 1);
  endfunction

  localparam logic [3:0] SETUP_LD   = load_val(SETUP_CYC);
  localparam logic [3:0] STROBE_LD  = load_val(STROBE_CYC);
  localparam logic [3:0] HOLD_LD    = load_val(HOLD_CYC);
  localparam logic [3:0] RECOVER_LD = load_val(RECOVERY_CYC);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE, RECOVER} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        is_write_reg;
  logic        is_local_reg;
  logic        rst_reg;
  logic [15:0] readdata_reg;
  logic        waitrequest_reg;
  logic [1:0]  otg_addr_reg;
  logic [15:0] otg_data_out_reg;
  logic        otg_data_oe_reg;
  logic        otg_cs_n_reg;
  logic        otg_rd_n_reg;
  logic        otg_wr_n_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= 4'd0;
      is_write_reg     <= 1'b0;
      is_local_reg     <= 1'b0;
      rst_reg          <= 1'b0;
      readdata_reg     <= 16'd0;
      waitrequest_reg  <= 1'b1;
      otg_addr_reg     <= 2'd0;
      otg_data_out_reg <= 16'd0;
      otg_data_oe_reg  <= 1'b0;
      otg_cs_n_reg     <= 1'b1;
      otg_rd_n_reg     <= 1'b1;
      otg_wr_n_reg     <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          waitrequest_reg <= 1'b1;
          if (bus.read || bus.write) begin
            // Write wins when both requests are presented together.
            is_write_reg <= bus.write;
            is_local_reg <= bus.address[2];
            if (!bus.address[2]) begin
              state_reg       <= SETUP;
              cnt_reg         <= SETUP_LD;
              otg_cs_n_reg    <= 1'b0;
              otg_addr_reg    <= bus.address[1:0];
              otg_data_oe_reg <= bus.write;
              if (bus.write)
                otg_data_out_reg <= bus.writedata;
            end else begin
              state_reg       <= DONE;
              waitrequest_reg <= 1'b0;
              if (bus.address == 3'd4) begin
                if (bus.write) rst_reg      <= bus.writedata[0];
                else           readdata_reg <= {15'd0, rst_reg};
              end else if (!bus.write) begin
                readdata_reg <= 16'd0;
              end
            end
          end
        end
        SETUP: begin
          if (cnt_reg == 4'd0) begin
            state_reg    <= STROBE;
            cnt_reg      <= STROBE_LD;
            otg_wr_n_reg <= ~is_write_reg;
            otg_rd_n_reg <= is_write_reg;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        STROBE: begin
          if (cnt_reg == 4'd0) begin
            state_reg    <= HOLD;
            cnt_reg      <= HOLD_LD;
            otg_wr_n_reg <= 1'b1;
            otg_rd_n_reg <= 1'b1;
            if (!is_write_reg)
              readdata_reg <= bus.otg_data_in;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        HOLD: begin
          if (cnt_reg == 4'd0) begin
            state_reg       <= DONE;
            otg_cs_n_reg    <= 1'b1;
            otg_data_oe_reg <= 1'b0;
            waitrequest_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        DONE: begin
          waitrequest_reg <= 1'b1;
          if (is_local_reg) begin
            state_reg <= IDLE;
          end else begin
            state_reg <= RECOVER;
            cnt_reg   <= RECOVER_LD;
          end
        end
        RECOVER: begin
          if (cnt_reg == 4'd0) state_reg <= IDLE;
          else                 cnt_reg   <= cnt_reg - 4'd1;
        end
        default: begin
          state_reg       <= IDLE;
          waitrequest_reg <= 1'b1;
          otg_cs_n_reg    <= 1'b1;
          otg_rd_n_reg    <= 1'b1;
          otg_wr_n_reg    <= 1'b1;
          otg_data_oe_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.readdata     = readdata_reg;
  assign bus.waitrequest  = waitrequest_reg;
  assign bus.otg_addr     = otg_addr_reg;
  assign bus.otg_data_out = otg_data_out_reg;
  assign bus.otg_data_oe  = otg_data_oe_reg;
  assign bus.otg_cs_n     = otg_cs_n_reg;
  assign bus.otg_rd_n     = otg_rd_n_reg;
  assign bus.otg_wr_n     = otg_wr_n_reg;
  assign bus.otg_rst_n    = ~rst_reg;

endmodule

// File: tb/tb_hpi_bus_master.sv
// Self-checking bench for hpi_bus_master: directed cases then random accesses,
// each cycle compared against a phase-window model derived from the timing parameters.
module tb_hpi_bus_master;
  localparam int unsigned P_SETUP   = 2;
  localparam int unsigned P_STROBE  = 6;
  localparam int unsigned P_HOLD    = 2;
  localparam int unsigned P_RECOVER = 4;

  localparam int S = (P_SETUP   == 0) ? 1 : int'(P_SETUP);
  localparam int T = (P_STROBE  == 0) ? 1 : int'(P_STROBE);
  localparam int H = (P_HOLD    == 0) ? 1 : int'(P_HOLD);
  localparam int R = (P_RECOVER == 0) ? 1 : int'(P_RECOVER);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  hpi_bus_master_if bus();

  hpi_bus_master #(
    .SETUP_CYC(P_SETUP), .STROBE_CYC(P_STROBE),
    .HOLD_CYC(P_HOLD), .RECOVERY_CYC(P_RECOVER)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [15:0] m_rd = 16'd0;   // model of readdata
  logic        m_rst = 1'b0;   // model of CTRL.RST
  int  last_done_cyc = 0;
  bit  prev_hold = 1'b0;
  int  wr_pulses = 0;
  int  rd_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access: drive in an IDLE cycle, accept on the next edge, check every cycle
  // until the controller is back in IDLE.
  task automatic do_txn(input logic [2:0] a, input logic rd, input logic wr,
                        input logic [15:0] d, input logic [15:0] din, input bit hold);
    bit is_wr;
    bit loc;
    int kdone, klast;
    logic [15:0] rd_after;
    logic        rst_after;
    is_wr = wr;
    loc   = a[2];
    rst_after = m_rst;
    rd_after  = m_rd;
    if (loc) begin
      if (is_wr) begin
        if (a == 3'd4) rst_after = d[0];
      end else begin
        rd_after = (a == 3'd4) ? {15'd0, m_rst} : 16'd0;
      end
      kdone = 1;
      klast = 1;
    end else begin
      if (!is_wr) rd_after = din;
      kdone = S + T + H + 1;
      klast = kdone + R;
    end

    @(negedge clk);
    check("idle_wait", {31'd0, bus.waitrequest}, 32'd1);
    check("idle_cs_n", {31'd0, bus.otg_cs_n}, 32'd1);
    bus.address = a; bus.read = rd; bus.write = wr;
    bus.writedata = d; bus.otg_data_in = din;
    @(posedge clk);
    wr_pulses = 0;
    rd_pulses = 0;

    for (int k = 1; k <= klast; k++) begin
      bit in_cs, in_str;
      logic [4:0] exp_vec;
      logic [15:0] exp_rdata;
      @(negedge clk);
      in_cs  = !loc && (k <= S + T + H);
      in_str = !loc && (k > S) && (k <= S + T);
      exp_vec = {~in_cs, ~(in_str && !is_wr), ~(in_str && is_wr), in_cs && is_wr, k != kdone};
      check($sformatf("pins a=%0d k=%0d {cs,rd,wr,oe,wait}", a, k),
            {27'd0, bus.otg_cs_n, bus.otg_rd_n, bus.otg_wr_n, bus.otg_data_oe, bus.waitrequest},
            {27'd0, exp_vec});
      check("strobe_safety",
            {31'd0, (bus.otg_cs_n && (!bus.otg_rd_n || !bus.otg_wr_n)) || (!bus.otg_rd_n && !bus.otg_wr_n)},
            32'd0);
      if (in_cs) check("otg_addr", {30'd0, bus.otg_addr}, {30'd0, a[1:0]});
      if (in_cs && is_wr) check("otg_data_out", {16'd0, bus.otg_data_out}, {16'd0, d});
      exp_rdata = (loc || k > S + T) ? rd_after : m_rd;
      check($sformatf("readdata k=%0d", k), {16'd0, bus.readdata}, {16'd0, exp_rdata});
      check("otg_rst_n", {31'd0, bus.otg_rst_n}, {31'd0, ~rst_after});
      if (!bus.otg_wr_n) wr_pulses++;
      if (!bus.otg_rd_n) rd_pulses++;
      if (k == 1 && !loc && prev_hold)
        check("b2b_gap", cyc - last_done_cyc, R + 2);
      if (k == kdone) last_done_cyc = cyc;
      @(posedge clk);
      if (k == kdone && !hold) begin
        #1;
        bus.read = 1'b0;
        bus.write = 1'b0;
      end
    end
    m_rd  = rd_after;
    m_rst = rst_after;
    prev_hold = hold && !loc;
    $display("txn addr=%0d %s data=%04h din=%04h readdata=%04h rst_n=%0b",
             a, is_wr ? "WR" : "RD", d, din, bus.readdata, bus.otg_rst_n);
  endtask

  initial begin
    bus.address = 3'd0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = 16'd0; bus.otg_data_in = 16'd0;
    repeat (2) @(negedge clk);
    check("reset_pins {cs,rd,wr,oe,wait}",
          {27'd0, bus.otg_cs_n, bus.otg_rd_n, bus.otg_wr_n, bus.otg_data_oe, bus.waitrequest},
          32'h1d);
    check("reset_addr_data", {14'd0, bus.otg_addr, bus.otg_data_out}, 32'd0);
    check("reset_readdata", {16'd0, bus.readdata}, 32'd0);
    check("reset_rst_n", {31'd0, bus.otg_rst_n}, 32'd1);
    reset_n = 1'b1;

    // Directed accesses
    do_txn(3'd2, 1'b0, 1'b1, 16'h1234, 16'h0000, 1'b0);
    do_txn(3'd0, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 1'b0);
    do_txn(3'd3, 1'b0, 1'b1, 16'h5A5A, 16'h0000, 1'b1);
    do_txn(3'd1, 1'b0, 1'b1, 16'hC3C3, 16'h0000, 1'b0);
    do_txn(3'd4, 1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0);
    do_txn(3'd4, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    do_txn(3'd1, 1'b1, 1'b1, 16'h00AA, 16'h7777, 1'b0);
    check("both_req_wr_pulses", wr_pulses, T);
    check("both_req_rd_pulses", rd_pulses, 0);
    do_txn(3'd6, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
    do_txn(3'd7, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
    do_txn(3'd5, 1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0);
    do_txn(3'd4, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    do_txn(3'd0, 1'b1, 1'b0, 16'h0000, 16'h1357, 1'b0);

    // Asynchronous reset in the middle of a write strobe
    @(negedge clk);
    bus.address = 3'd2; bus.write = 1'b1; bus.writedata = 16'hA5A5;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_reset_wr_n", {31'd0, bus.otg_wr_n}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset {cs,rd,wr,oe,wait}",
          {27'd0, bus.otg_cs_n, bus.otg_rd_n, bus.otg_wr_n, bus.otg_data_oe, bus.waitrequest},
          32'h1d);
    check("mid_reset_readdata", {16'd0, bus.readdata}, 32'd0);
    check("mid_reset_rst_n", {31'd0, bus.otg_rst_n}, 32'd1);
    bus.write = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_rd = 16'd0; m_rst = 1'b0; prev_hold = 1'b0;
    $display("txn reset during strobe cs_n=%0b wr_n=%0b", bus.otg_cs_n, bus.otg_wr_n);
    do_txn(3'd3, 1'b1, 1'b0, 16'h0000, 16'h2468, 1'b0);

    // Random accesses
    for (int n = 0; n < 24; n++) begin
      logic [2:0] a;
      int op;
      bit hold;
      a    = 3'($urandom_range(0, 7));
      op   = $urandom_range(0, 2);
      hold = (n != 23) && ($urandom_range(0, 3) == 0);
      do_txn(a, op != 1, op != 0, 16'($urandom), 16'($urandom), hold);
    end
    bus.read = 1'b0; bus.write = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
